button_event_decoder: RTL

- Consumes the clean, debounced level of one push-button and converts it into single-cycle event pulses: press, release, click (short press), long-press and auto-repeat.
- Sits directly downstream of a button debouncer, in the same clock domain.
- Game and menu logic react to events rather than polling levels.

---
 rtl/button_event_decoder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/button_event_decoder.sv
// ============================================================================
// Module   : button_event_decoder
// Purpose  : Turns a debounced button level into press / release / click /
//            long-press / auto-repeat pulses plus a held level.
//            Optional macro BUTTON_REPEAT_EN enables the auto-repeat pulse.
// Revision : 1.0 - initial release
// ============================================================================
// Note: "release" and "repeat" are language keywords, so those two outputs
// are exposed as release_event and repeat_event.
`default_nettype none

module button_event_decoder #(
    parameter int LONG_CYCLES   = 27000000,
    parameter int REPEAT_CYCLES = 6750000,
    parameter int CNT_WIDTH     = 25
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clean,
    output logic press,
    output logic release_event,
    output logic click,
    output logic long_press,
    output logic repeat_event,
    output logic held
);

    localparam logic [1:0] c_st_lockout = 2'd0;
    localparam logic [1:0] c_st_idle    = 2'd1;
    localparam logic [1:0] c_st_pressed = 2'd2;
    localparam logic [1:0] c_st_long    = 2'd3;

    localparam logic [CNT_WIDTH-1:0] c_cnt_one   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_long_last = CNT_WIDTH'(LONG_CYCLES - 1);

    // Elaboration-time sanity checks on the configuration
    if (LONG_CYCLES < 2) begin : g_chk_long_min
        $error("button_event_decoder: LONG_CYCLES must be >= 2");
    end
    if (REPEAT_CYCLES < 1) begin : g_chk_repeat_min
        $error("button_event_decoder: REPEAT_CYCLES must be >= 1");
    end
    if (((64'(LONG_CYCLES) - 64'd1) >> CNT_WIDTH) != 64'd0) begin : g_chk_long_fit
        $error("button_event_decoder: CNT_WIDTH too small for LONG_CYCLES");
    end

    logic [1:0]           r_state;
    logic [CNT_WIDTH-1:0] r_count;

`ifdef BUTTON_REPEAT_EN
    localparam logic [CNT_WIDTH-1:0] c_repeat_last = CNT_WIDTH'(REPEAT_CYCLES - 1);

    if (((64'(REPEAT_CYCLES) - 64'd1) >> CNT_WIDTH) != 64'd0) begin : g_chk_repeat_fit
        $error("button_event_decoder: CNT_WIDTH too small for REPEAT_CYCLES");
    end
`else
    assign repeat_event = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= c_st_lockout;
            r_count       <= '0;
            press         <= 1'b0;
            release_event <= 1'b0;
            click         <= 1'b0;
            long_press    <= 1'b0;
`ifdef BUTTON_REPEAT_EN
            repeat_event  <= 1'b0;
`endif
            held          <= 1'b0;
        end else begin
            press         <= 1'b0;
            release_event <= 1'b0;
            click         <= 1'b0;
            long_press    <= 1'b0;
`ifdef BUTTON_REPEAT_EN
            repeat_event  <= 1'b0;
`endif
            case (r_state)
                // A button still held when reset ends must be let go first
                c_st_lockout: begin
                    if (!clean) begin
                        r_state <= c_st_idle;
                    end
                end

                c_st_idle: begin
                    if (clean) begin
                        press   <= 1'b1;
                        held    <= 1'b1;
                        r_count <= '0;
                        r_state <= c_st_pressed;
                    end
                end

                // Release is tested first so it wins over a coincident long_press
                c_st_pressed: begin
                    if (!clean) begin
                        release_event <= 1'b1;
                        click         <= 1'b1;
                        held          <= 1'b0;
                        r_state       <= c_st_idle;
                    end else if (r_count == c_long_last) begin
                        long_press <= 1'b1;
                        r_count    <= '0;
                        r_state    <= c_st_long;
                    end else begin
                        r_count <= r_count + c_cnt_one;
                    end
                end

                c_st_long: begin
                    if (!clean) begin
                        release_event <= 1'b1;
                        held          <= 1'b0;
                        r_state       <= c_st_idle;
                    end else begin
`ifdef BUTTON_REPEAT_EN
                        if (r_count == c_repeat_last) begin
                            repeat_event <= 1'b1;
                            r_count      <= '0;
                        end else begin
                            r_count <= r_count + c_cnt_one;
                        end
`else
                        r_count <= '0;
`endif
                    end
                end

                default: begin
                    r_state <= c_st_lockout;
                    held    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
